dbus_xfer_ctl: RTL and testbench
================================

Name: dbus_xfer_ctl

Overview:
Sequences register-to-register transfers over the shared open-drain data bus (dbus). Each register exposes a read strobe (rda, drives dbus) and a write strobe (wra, a rising-edge capture clock). The block arbitrates between two requesters (CPU microsequencer, front-panel loader) and generates non-overlapping, glitch-free rda/wra strobe sequences so a destination captures only after the source has driven the bus for a settle interval. It sits between the control unit and the register file strobes.

Parameters:
NREG, 8, number of registers on dbus; strobe vector width
IW, 3, register index width; NREG <= 2**IW
SETTLE, 2, cycles rda is held before the wra rising edge (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
req0  input  1  requester 0 (CPU) transfer request, level
src0  input  IW  requester 0 source register index
dst0  input  IW  requester 0 destination register index
ack0  output  1  requester 0 transfer complete, 1-cycle pulse
req1  input  1  requester 1 (panel) transfer request, level
src1  input  IW  requester 1 source index
dst1  input  IW  requester 1 destination index
ack1  output  1  requester 1 transfer complete, 1-cycle pulse
rda  output  NREG  one-hot read strobes, all-zero when bus idle
wra  output  NREG  one-hot write strobes (capture on rising edge)
busy  output  1  transfer in progress (state != IDLE)
gnt  output  1  index of currently/last granted requester

Behaviour:
- Reset (async, immediate): rda=0, wra=0, ack0=ack1=0, busy=0, gnt=0, state=IDLE, rr pointer=0; a transfer in flight is abandoned with no ack and no strobe glitch (all strobes are registered, cleared by rst).
- All outputs are registered; no combinational path from inputs to rda/wra.
- States: IDLE -> DRIVE -> CAPT -> HOLD -> DONE -> IDLE.
- IDLE: if any req, grant per arbitration, latch src/dst of winner into internal registers (inputs may change after grant), go DRIVE. busy=1 from next cycle.
- DRIVE: rda[src]=1 for SETTLE cycles (down-counter), wra=0.
- CAPT: rda[src] held, wra[dst]=1 for exactly 1 cycle.
- HOLD: wra=0, rda[src] held 1 cycle (hold time after capture edge).
- DONE: rda=0, ack of granted requester=1 for 1 cycle; return IDLE.
- Latency req->ack (src!=dst): SETTLE+4 cycles; req->wra rising edge: SETTLE+2.
- src==dst: no strobes at all; IDLE -> DONE directly, ack after 2 cycles (no-op transfer).
- Index >= NREG: treated as no-op like src==dst; no strobe bit set out of range.
- Handshake: requester holds req until ack; must drop req the cycle after ack, otherwise a req still high in IDLE is a new request.
- Arbitration (default): round-robin; on simultaneous req, grant the requester not granted last; pointer updates at each grant.
- rda and wra are never both asserted to different-than-intended registers; at most one rda bit and one wra bit high at any time.

Optional Feature:
Macro DBUS_FIXED_PRIO_EN. Defined: fixed priority, requester 0 (CPU) always wins simultaneous requests; round-robin pointer removed. Undefined: round-robin as above.

Decomposition:
- Package dbus_xfer_pkg: state enum (IDLE, DRIVE, CAPT, HOLD, DONE), encoding constants, one-hot decode function.
- One sub-module natural: dbus_xfer_arb (2-way arbiter with rr pointer / fixed-priority variant, outputs grant valid + index).

Test Plan:
- Reset mid-DRIVE: req0 src=1 dst=2, assert rst during DRIVE -> rda=wra=0 immediately, no ack0, busy=0; after release idle.
- Single transfer, SETTLE=2: req0 src=3 dst=5 -> rda[3] high 4 cycles (DRIVE x2, CAPT, HOLD), wra[5] 1-cycle pulse in 3rd cycle of rda, ack0 at cycle 6.
- Simultaneous req0/req1 twice with rr pointer=0 -> first grant requester 1? no: grant 0 then 1; with DBUS_FIXED_PRIO_EN both grants go to 0 while req0 held.
- src==dst=4 -> no rda/wra bits ever high, ack after 2 cycles.
- Source index 9 with NREG=8 -> no strobes, ack issued; dst model unchanged.
- Input change after grant: change src0 during DRIVE -> strobes keep latched index; dbus model captures latched source value into dst.

Source files
------------

// File: rtl/dbus_xfer_pkg.sv
// -----------------------------------------------------------------------------
// dbus_xfer_pkg
// Shared definitions for the dbus transfer controller:
//   - xfer_state_t : sequencer states (IDLE, DRIVE, CAPT, HOLD, DONE)
//   - REQ_CPU / REQ_PANEL : requester index encodings used for gnt
//   - onehot_dec() : index -> one-hot strobe vector, zero when out of range
// Configuration macro used by the block: DBUS_FIXED_PRIO_EN (see dbus_xfer_arb).
// -----------------------------------------------------------------------------
package dbus_xfer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_CAPT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } xfer_state_t;

  localparam logic REQ_CPU   = 1'b0;
  localparam logic REQ_PANEL = 1'b1;

  // Widest strobe vector the decoder supports; NREG must not exceed this.
  localparam int unsigned STROBE_MAX = 64;

  // Decode a register index into a one-hot strobe. Indices at or above nreg
  // decode to all-zero so no strobe can ever be raised for a missing register.
  function automatic logic [STROBE_MAX-1:0] onehot_dec(input int unsigned idx,
                                                       input int unsigned nreg);
    logic [STROBE_MAX-1:0] v;
    v = '0;
    if ((idx < nreg) && (idx < STROBE_MAX)) begin
      v = 64'd1 << idx;
    end
    return v;
  endfunction

endpackage

// File: rtl/dbus_xfer_arb.sv
// -----------------------------------------------------------------------------
// dbus_xfer_arb
// Two-way arbiter between requester 0 (CPU) and requester 1 (front panel).
//   Default build     : round-robin. r_ptr names the requester that wins a
//                       tie; it flips to the other requester on every grant
//                       taken (i_take). Resets to requester 0.
//   DBUS_FIXED_PRIO_EN: fixed priority, requester 0 always wins a tie; no
//                       pointer state.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_req0, i_req1    request levels
//   i_take            the controller is accepting the current grant this cycle
//   o_gnt_vld         at least one request is pending
//   o_gnt_idx         index of the requester that would be granted
// -----------------------------------------------------------------------------
module dbus_xfer_arb (
  input  logic clk,
  input  logic rst,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_take,
  output logic o_gnt_vld,
  output logic o_gnt_idx
);

  assign o_gnt_vld = i_req0 | i_req1;

`ifdef DBUS_FIXED_PRIO_EN

  // Requester 1 only wins when requester 0 is silent.
  assign o_gnt_idx = ~i_req0;

  logic w_unused_fixed;
  assign w_unused_fixed = clk ^ rst ^ i_take;

`else

  logic r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (i_take && o_gnt_vld) begin
      r_ptr <= ~o_gnt_idx;
    end
  end

  always_comb begin
    if (i_req0 && i_req1) begin
      o_gnt_idx = r_ptr;
    end else begin
      // With zero or one request, the index simply follows requester 1.
      o_gnt_idx = i_req1;
    end
  end

`endif

endmodule

// File: rtl/dbus_xfer_ctl.sv
// -----------------------------------------------------------------------------
// dbus_xfer_ctl
// Sequences one register-to-register transfer at a time over the shared
// open-drain dbus. Source read strobe rda[src] drives the bus for SETTLE
// cycles before the destination write strobe wra[dst] pulses for one cycle,
// and rda stays up one further cycle as hold time after the capture edge.
// Transfers with src==dst or any index >= NREG are no-ops: no strobes, ack
// only.
//
// Handshake: a requester raises req (level) with src/dst and holds it until
// its ack pulses for one cycle; src/dst are latched at grant, so they may
// change afterwards. While an ack is being presented no new grant is made,
// which gives the requester that cycle to drop req; a req still high after
// that is treated as a new request.
//
// Timing (req seen in cycle 0, src != dst): busy cycles 1..SETTLE+3,
// rda[src] cycles 2..SETTLE+3, wra[dst] cycle SETTLE+2, ack cycle SETTLE+4.
// No-op: busy cycle 1, ack cycle 2.
//
// Ports:
//   clk, rst                asynchronous active-high reset
//   req0/src0/dst0/ack0     requester 0 (CPU)
//   req1/src1/dst1/ack1     requester 1 (front panel)
//   rda[NREG], wra[NREG]    one-hot registered read / write strobes
//   busy                    a transfer is in progress
//   gnt                     current / last granted requester
//   o_dbg_state             sequencer state, for observation only
// Configuration: DBUS_FIXED_PRIO_EN selects fixed priority in dbus_xfer_arb.
// -----------------------------------------------------------------------------
module dbus_xfer_ctl
  import dbus_xfer_pkg::*;
#(
  parameter int NREG   = 8,
  parameter int IW     = 3,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0,
  input  logic [IW-1:0]   src0,
  input  logic [IW-1:0]   dst0,
  output logic            ack0,
  input  logic            req1,
  input  logic [IW-1:0]   src1,
  input  logic [IW-1:0]   dst1,
  output logic            ack1,
  output logic [NREG-1:0] rda,
  output logic [NREG-1:0] wra,
  output logic            busy,
  output logic            gnt,
  output xfer_state_t     o_dbg_state
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  xfer_state_t      r_state;
  xfer_state_t      w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [IW-1:0]    r_src;
  logic [IW-1:0]    r_dst;
  logic             r_gnt;
  logic [NREG-1:0]  r_rda;
  logic [NREG-1:0]  r_wra;
  logic             r_ack0;
  logic             r_ack1;
  logic             r_busy;

  logic             w_gnt_vld;
  logic             w_gnt_idx;
  logic             w_take;
  logic [IW-1:0]    w_src;
  logic [IW-1:0]    w_dst;
  logic             w_noop;
  logic [STROBE_MAX-1:0] w_rda_full;
  logic [STROBE_MAX-1:0] w_wra_full;
  logic [2*STROBE_MAX-1:0] w_unused_dec;

  dbus_xfer_arb u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req0    (req0),
    .i_req1    (req1),
    .i_take    (w_take),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt_idx (w_gnt_idx)
  );

  assign w_src  = w_gnt_idx ? src1 : src0;
  assign w_dst  = w_gnt_idx ? dst1 : dst0;
  assign w_noop = (w_src == w_dst) || (32'(w_src) >= NREG) || (32'(w_dst) >= NREG);

  // Next-state logic. A pending ack blocks new grants for that one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_take      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_vld && !(r_ack0 || r_ack1)) begin
          w_take = 1'b1;
          if (w_noop) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_DRIVE;
            w_cnt_nxt   = CW'(SETTLE - 1);
          end
        end
      end
      ST_DRIVE: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_CAPT;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_CAPT: w_state_nxt = ST_HOLD;
      ST_HOLD: w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_src   <= '0;
      r_dst   <= '0;
      r_gnt   <= REQ_CPU;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_take) begin
        r_src <= w_src;
        r_dst <= w_dst;
        r_gnt <= w_gnt_idx;
      end
    end
  end

  assign w_rda_full   = onehot_dec(32'(r_src), NREG);
  assign w_wra_full   = onehot_dec(32'(r_dst), NREG);
  assign w_unused_dec = {w_rda_full, w_wra_full};

  // Strobes are registered copies of the current state, so they lag the
  // state by one cycle and cannot glitch on input changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rda  <= '0;
      r_wra  <= '0;
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_rda  <= ((r_state == ST_DRIVE) || (r_state == ST_CAPT) || (r_state == ST_HOLD))
                ? w_rda_full[NREG-1:0] : '0;
      r_wra  <= (r_state == ST_CAPT) ? w_wra_full[NREG-1:0] : '0;
      r_ack0 <= (r_state == ST_DONE) && (r_gnt == REQ_CPU);
      r_ack1 <= (r_state == ST_DONE) && (r_gnt == REQ_PANEL);
      r_busy <= (w_state_nxt != ST_IDLE);
    end
  end

  assign rda         = r_rda;
  assign wra         = r_wra;
  assign ack0        = r_ack0;
  assign ack1        = r_ack1;
  assign busy        = r_busy;
  assign gnt         = r_gnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dbus_xfer_ctl.sv
// -----------------------------------------------------------------------------
// tb_dbus_xfer_ctl
// Bench for dbus_xfer_ctl with NREG=8, IW=4 (so indices 8..15 exist on the
// request side), SETTLE=2. A register-file stand-in captures the wired-AND
// dbus value on each wra rising edge; expected contents come from the rule
// "dst takes src's value unless the transfer is a no-op".
// -----------------------------------------------------------------------------
module tb_dbus_xfer_ctl;
  import dbus_xfer_pkg::*;

  localparam int NREG   = 8;
  localparam int IW     = 4;
  localparam int SETTLE = 2;
  localparam int DW     = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            req0, req1, ack0, ack1, busy, gnt;
  logic [IW-1:0]   src0, dst0, src1, dst1;
  logic [NREG-1:0] rda, wra;
  xfer_state_t     dbg_state;

  dbus_xfer_ctl #(.NREG(NREG), .IW(IW), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .src0(src0), .dst0(dst0), .ack0(ack0),
    .req1(req1), .src1(src1), .dst1(dst1), .ack1(ack1),
    .rda(rda), .wra(wra), .busy(busy), .gnt(gnt),
    .o_dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- register file stand-in on dbus ----------------
  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(i * 16'h1357) ^ 16'hA5C3;
  endfunction

  logic [DW-1:0]   dut_file[NREG];
  logic [DW-1:0]   exp_file[NREG];
  logic [NREG-1:0] prev_wra = '0;
  bit              file_ready = 1'b0;

  always @(negedge clk) begin
    logic [DW-1:0] bus;
    if (!file_ready) begin
      for (int i = 0; i < NREG; i++) dut_file[i] = init_val(i);
      file_ready = 1'b1;
    end
    bus = '1;
    for (int i = 0; i < NREG; i++) if (rda[i]) bus = bus & dut_file[i];
    for (int i = 0; i < NREG; i++) if (wra[i] && !prev_wra[i]) dut_file[i] = bus;
    prev_wra = wra;
  end

  // ---------------- reference model state ----------------
  int mdl_prefer = 0;   // requester that wins a tie
  bit mdl_gnt    = 1'b0;

  // ---------------- driver + per-cycle scoreboard ----------------
  task automatic run_xfer(input bit u0, input bit u1,
                          input logic [IW-1:0] s0, input logic [IW-1:0] d0,
                          input logic [IW-1:0] s1, input logic [IW-1:0] d1,
                          input bit chg,
                          output int first_obs, output int lat_obs,
                          output int first_mdl, output int lat_mdl);
    int order[$];
    logic [IW-1:0]   ts[2], td[2];
    logic [NREG-1:0] e_rda[64], e_wra[64];
    bit e_ack0[64], e_ack1[64], e_busy[64], e_gnt[64];
    int g, lat, last, w;
    bit noop, seen0, seen1;
    ts[0] = s0; td[0] = d0; ts[1] = s1; td[1] = d1;
    for (int c = 0; c < 64; c++) begin
      e_rda[c] = '0; e_wra[c] = '0; e_ack0[c] = 0; e_ack1[c] = 0;
      e_busy[c] = 0; e_gnt[c] = mdl_gnt;
    end
`ifdef DBUS_FIXED_PRIO_EN
    first_mdl = u0 ? 0 : 1;
`else
    first_mdl = (u0 && u1) ? mdl_prefer : (u0 ? 0 : 1);
`endif
    order.push_back(first_mdl);
    if (u0 && u1) order.push_back(1 - first_mdl);
    g = 0; last = 0; lat_mdl = 0;
    foreach (order[k]) begin
      w    = order[k];
      noop = (ts[w] == td[w]) || (ts[w] >= NREG) || (td[w] >= NREG);
      lat  = noop ? 2 : SETTLE + 4;
      if (k == 0) lat_mdl = lat;
      for (int c = g + 1; c < g + lat; c++) e_busy[c] = 1;
      for (int c = g + 1; c < 64; c++) e_gnt[c] = w[0];
      if (!noop) begin
        for (int c = g + 2; c <= g + SETTLE + 3; c++) e_rda[c] = NREG'(1) << ts[w];
        e_wra[g + SETTLE + 2] = NREG'(1) << td[w];
        exp_file[td[w]] = exp_file[ts[w]];
      end
      if (w == 0) e_ack0[g + lat] = 1; else e_ack1[g + lat] = 1;
      last = g + lat;
      g    = last + 1;
      mdl_prefer = 1 - w;
      mdl_gnt    = w[0];
    end

    first_obs = -1; lat_obs = -1; seen0 = 0; seen1 = 0;
    @(posedge clk); #1;
    req0 = u0; req1 = u1; src0 = s0; dst0 = d0; src1 = s1; dst1 = d1;
    for (int n = 0; n <= last + 1; n++) begin
      @(negedge clk);
      check($sformatf("trace c%0d {rda,wra,ack0,ack1,busy,gnt}", n),
            64'({rda, wra, ack0, ack1, busy, gnt}),
            64'({e_rda[n], e_wra[n], e_ack0[n], e_ack1[n], e_busy[n], e_gnt[n]}));
      if (ack0 && !seen0) begin
        seen0 = 1;
        if (first_obs < 0) begin first_obs = 0; lat_obs = n; end
      end
      if (ack1 && !seen1) begin
        seen1 = 1;
        if (first_obs < 0) begin first_obs = 1; lat_obs = n; end
      end
      @(posedge clk); #1;
      if (seen0) req0 = 0;
      if (seen1) req1 = 0;
      if (chg && n == 1) src0 = s0 ^ 4'd1;
    end
    if (u0) check("ack0 seen", 64'(seen0), 64'd1);
    if (u1) check("ack1 seen", 64'(seen1), 64'd1);
    req0 = 0; req1 = 0;
    for (int i = 0; i < NREG; i++)
      check($sformatf("regfile[%0d]", i), 64'(dut_file[i]), 64'(exp_file[i]));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit            u0;
    bit            u1;
    logic [IW-1:0] s0, d0, s1, d1;
    bit            chg;
    int            exp_first;
    int            exp_lat;
  } vec_t;

  function automatic vec_t mk(bit u0, bit u1, int s0, int d0, int s1, int d1,
                              bit chg, int ef, int el);
    vec_t v;
    v.u0 = u0; v.u1 = u1; v.s0 = IW'(s0); v.d0 = IW'(d0); v.s1 = IW'(s1); v.d1 = IW'(d1);
    v.chg = chg; v.exp_first = ef; v.exp_lat = el;
    return v;
  endfunction

  initial begin
    vec_t tbl[10];
    int fo, lo, fm, lm, mode;
    logic [IW-1:0] rs0, rd0, rs1, rd1;

    // Expectations follow the round-robin order starting from requester 0.
    tbl[0] = mk(1, 0, 3, 5,  0, 0, 0, 0, 6);  // plain transfer
    tbl[1] = mk(0, 1, 0, 0,  4, 4, 0, 1, 2);  // src==dst no-op
    tbl[2] = mk(1, 1, 1, 6,  2, 7, 0, 0, 6);  // tie, pointer at 0
    tbl[3] = mk(1, 0, 2, 6,  0, 0, 1, 0, 6);  // src0 changes during DRIVE
    tbl[4] = mk(1, 1, 7, 0,  6, 1, 0, 1, 6);  // tie, pointer at 1
    tbl[5] = mk(1, 0, 9, 1,  0, 0, 0, 0, 2);  // source out of range
    tbl[6] = mk(0, 1, 0, 0,  2, 12, 0, 1, 2); // destination out of range
    tbl[7] = mk(1, 1, 5, 5,  6, 0, 0, 0, 2);  // tie, winner is a no-op
    tbl[8] = mk(1, 1, 3, 2,  0, 0, 0, 0, 6);  // tie, loser is a no-op
    tbl[9] = mk(0, 1, 0, 0,  0, 3, 0, 1, 6);

    for (int i = 0; i < NREG; i++) exp_file[i] = init_val(i);
    req0 = 0; req1 = 0; src0 = '0; dst0 = '0; src1 = '0; dst1 = '0;
    rst = 1'b0;
    #1 rst = 1'b1;

    @(negedge clk);
    check("reset outputs {rda,wra,ack0,ack1,busy,gnt}",
          64'({rda, wra, ack0, ack1, busy, gnt}), 64'd0);
    check("reset state", 64'(dbg_state), 64'(ST_IDLE));
    @(posedge clk); #1 rst = 1'b0;

    // Reset during DRIVE abandons the transfer with no ack and no capture.
    @(posedge clk); #1;
    req0 = 1; src0 = 4'd1; dst0 = 4'd2;
    @(posedge clk); @(posedge clk); #1;
    check("rda before mid-drive reset", 64'(rda), 64'h02);
    rst = 1'b1; req0 = 0;
    #1;
    check("mid-drive reset {rda,wra,ack0,busy}", 64'({rda, wra, ack0, busy}), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check($sformatf("post-reset idle c%0d", n),
            64'({rda, wra, ack0, ack1, busy, dbg_state}), 64'(ST_IDLE));
    end
    mdl_prefer = 0; mdl_gnt = 1'b0;

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      run_xfer(tbl[i].u0, tbl[i].u1, tbl[i].s0, tbl[i].d0, tbl[i].s1, tbl[i].d1,
               tbl[i].chg, fo, lo, fm, lm);
      check($sformatf("vec%0d first ack", i), 64'(fo), 64'(tbl[i].exp_first));
      check($sformatf("vec%0d latency", i), 64'(lo), 64'(tbl[i].exp_lat));
    end

    // Randomized transfers against the model.
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 2);
      rs0 = IW'($urandom_range(0, 9)); rd0 = IW'($urandom_range(0, 9));
      rs1 = IW'($urandom_range(0, 9)); rd1 = IW'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) rd0 = rs0;
      if ($urandom_range(0, 3) == 0) rd1 = rs1;
      run_xfer(mode != 1, mode != 0, rs0, rd0, rs1, rd1, 1'b0, fo, lo, fm, lm);
      check($sformatf("rand%0d first ack", i), 64'(fo), 64'(fm));
      check($sformatf("rand%0d latency", i), 64'(lo), 64'(lm));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
